// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle FETCH/DECODE/EXEC/MEM/WB control FSM with latched-opcode decode
// Optional memory watchdog is compiled in with `define MC_MEM_TIMEOUT_EN.
module multicycle_ctrl #(
   parameter int OPCODE_W    = 6,
   parameter int EXEC_W      = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   input  logic                branch_taken,
   input  logic                freeze,
   output logic [2:0]          state_o,
   output logic                ir_en,
   output logic                pc_en,
   output logic                pc_src,
   output logic                iord,
   output logic                mem_r_en,
   output logic                mem_w_en,
   output logic                wb_en,
   output logic [EXEC_W-1:0]   exec_cmd,
   output logic                is_imm,
   output logic                single_src,
   output logic                if_store_bne,
   output logic [1:0]          branch_type,
   output logic                instr_done,
   output logic                illegal_op,
   output logic                mem_err
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_e;

   typedef enum logic [2:0] {C_NOP, C_ALU, C_LD, C_ST, C_BR, C_ILL} cls_e;

   typedef struct packed {
      logic [3:0] cmd;
      logic       imm;
      logic       ss;
      logic       sb;
      logic [1:0] bt;
   } fields_t;

   if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
      $error("MEM_TIMEOUT must be in 1..255");
   end

   // Any set bit above the 6-bit opcode map makes the opcode illegal.
   function automatic cls_e op_class(input logic [OPCODE_W-1:0] op);
      cls_e c;
      case (op[5:0])
         6'h00:                                           c = C_NOP;
         6'h01, 6'h03, 6'h05, 6'h06, 6'h07, 6'h08,
         6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h20, 6'h21:        c = C_ALU;
         6'h24:                                           c = C_LD;
         6'h25:                                           c = C_ST;
         6'h28, 6'h29, 6'h2A:                             c = C_BR;
         default:                                         c = C_ILL;
      endcase
      if ((op >> 6) != '0) c = C_ILL;
      return c;
   endfunction

   function automatic fields_t op_fields(input logic [5:0] op);
      fields_t f;
      f = '0;
      case (op)
         6'h03:        f.cmd = 4'b0010;
         6'h05:        f.cmd = 4'b0100;
         6'h06:        f.cmd = 4'b0101;
         6'h07:        f.cmd = 4'b0110;
         6'h08:        f.cmd = 4'b0111;
         6'h09, 6'h0A: f.cmd = 4'b1000;
         6'h0B:        f.cmd = 4'b1001;
         6'h0C:        f.cmd = 4'b1010;
         6'h20, 6'h24: begin f.imm = 1'b1; f.ss = 1'b1; end
         6'h21:        begin f.cmd = 4'b0010; f.imm = 1'b1; f.ss = 1'b1; end
         6'h25:        begin f.imm = 1'b1; f.sb = 1'b1; end
         6'h28:        begin f.imm = 1'b1; f.ss = 1'b1; f.bt = 2'b01; end
         6'h29:        begin f.imm = 1'b1; f.sb = 1'b1; f.bt = 2'b10; end
         6'h2A:        begin f.imm = 1'b1; f.ss = 1'b1; f.bt = 2'b11; end
         default:      f = '0;
      endcase
      return f;
   endfunction

   state_e              state_q, state_d;
   logic [OPCODE_W-1:0] opcode_q, opcode_d;
   cls_e                cls_in, cls_q;
   fields_t             fld_q;
   logic                tmo;

   assign cls_in = op_class(opcode);
   assign cls_q  = op_class(opcode_q);
   assign fld_q  = op_fields(opcode_q[5:0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_FETCH;
         opcode_q <= '0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
      end
   end

`ifdef MC_MEM_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   logic       in_wait;

   assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM);
   assign tmo     = in_wait && !freeze && !mem_ready && (cnt_q == 8'(MEM_TIMEOUT));

   always_comb begin
      cnt_d = cnt_q;
      if (freeze)
         cnt_d = cnt_q;
      else if (tmo || state_d != state_q)
         cnt_d = '0;
      else if (in_wait && !mem_ready)
         cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      opcode_d     = opcode_q;
      state_o      = state_q;
      ir_en        = 1'b0;
      pc_en        = 1'b0;
      pc_src       = 1'b0;
      iord         = 1'b0;
      mem_r_en     = 1'b0;
      mem_w_en     = 1'b0;
      wb_en        = 1'b0;
      exec_cmd     = '0;
      is_imm       = 1'b0;
      single_src   = 1'b0;
      if_store_bne = 1'b0;
      branch_type  = 2'b00;
      instr_done   = 1'b0;
      illegal_op   = 1'b0;
      mem_err      = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_r_en = 1'b1;
            if (mem_ready) begin
               ir_en   = 1'b1;
               pc_en   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            opcode_d = opcode;
            case (cls_in)
               C_NOP:   begin instr_done = 1'b1; state_d = S_FETCH; end
               C_ILL:   begin illegal_op = 1'b1; state_d = S_FETCH; end
               default: state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (cls_q)
               C_ALU:       state_d = S_WB;
               C_LD, C_ST:  state_d = S_MEM;
               C_BR: begin
                  if (fld_q.bt == 2'b11 || branch_taken) begin
                     pc_en  = 1'b1;
                     pc_src = 1'b1;
                  end
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end
               default:     state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            iord     = 1'b1;
            mem_r_en = (cls_q == C_LD);
            mem_w_en = (cls_q != C_LD);
            if (mem_ready) begin
               if (cls_q == C_LD) begin
                  state_d = S_WB;
               end else begin
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end
            end
         end
         S_WB: begin
            wb_en      = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
         exec_cmd     = EXEC_W'(fld_q.cmd);
         is_imm       = fld_q.imm;
         single_src   = fld_q.ss;
         if_store_bne = fld_q.sb;
         branch_type  = fld_q.bt;
      end

      if (tmo) begin
         ir_en    = 1'b0;
         pc_en    = 1'b0;
         mem_r_en = 1'b0;
         mem_w_en = 1'b0;
         mem_err  = 1'b1;
         state_d  = S_FETCH;
      end

      // Freeze parks the FSM; decode fields follow the held opcode_q.
      if (freeze) begin
         state_d    = state_q;
         opcode_d   = opcode_q;
         ir_en      = 1'b0;
         pc_en      = 1'b0;
         mem_r_en   = 1'b0;
         mem_w_en   = 1'b0;
         wb_en      = 1'b0;
         instr_done = 1'b0;
         illegal_op = 1'b0;
      end

      if (rst) begin
         state_o      = 3'd0;
         ir_en        = 1'b0;
         pc_en        = 1'b0;
         pc_src       = 1'b0;
         iord         = 1'b0;
         mem_r_en     = 1'b0;
         mem_w_en     = 1'b0;
         wb_en        = 1'b0;
         exec_cmd     = '0;
         is_imm       = 1'b0;
         single_src   = 1'b0;
         if_store_bne = 1'b0;
         branch_type  = 2'b00;
         instr_done   = 1'b0;
         illegal_op   = 1'b0;
         mem_err      = 1'b0;
      end
   end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
// Opcode table pass, hand-written stall/reset sequences, then randomized instructions against a phase-list model.
module tb_multicycle_ctrl;
   logic       clk = 1'b0;
   logic       rst, mem_ready, branch_taken, freeze;
   logic [5:0] opcode;
   logic [2:0] state_o;
   logic       ir_en, pc_en, pc_src, iord, mem_r_en, mem_w_en, wb_en;
   logic [3:0] exec_cmd;
   logic       is_imm, single_src, if_store_bne;
   logic [1:0] branch_type;
   logic       instr_done, illegal_op, mem_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .branch_taken(branch_taken), .freeze(freeze), .state_o(state_o),
      .ir_en(ir_en), .pc_en(pc_en), .pc_src(pc_src), .iord(iord),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en),
      .exec_cmd(exec_cmd), .is_imm(is_imm), .single_src(single_src),
      .if_store_bne(if_store_bne), .branch_type(branch_type),
      .instr_done(instr_done), .illegal_op(illegal_op), .mem_err(mem_err)
   );

   // kind: 0 NOP, 1 ALU, 2 LD, 3 ST, 4 branch, 5 illegal
   typedef struct {
      logic [5:0] op;
      int         kind;
      int         lat;
      logic [3:0] cmd;
      logic       imm;
      logic       ss;
      logic       sb;
      logic [1:0] bt;
   } vec_t;

   localparam int NV = 22;
   vec_t tbl[NV];

   function automatic vec_t mk(input logic [5:0] op, input int kind, input int lat,
                               input logic [3:0] cmd, input logic imm, input logic ss,
                               input logic sb, input logic [1:0] bt);
      vec_t v;
      v.op = op; v.kind = kind; v.lat = lat; v.cmd = cmd;
      v.imm = imm; v.ss = ss; v.sb = sb; v.bt = bt;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Walks the instruction's phase list: a phase is left on an unfrozen cycle,
   // except FETCH/MEM which also need mem_ready.
   task automatic run_instr(input int idx, input int p_wait, input int p_frz);
      vec_t v;
      int   ph[$];
      int   pi, cyc, stalls, fd, cur;
      int   n_wb, n_memw, n_memr, n_pc, n_pcsrc, n_ir;
      int   e_memw, e_memr, e_pc;
      bit   adv, last, ended;
      v = tbl[idx];
      ph.push_back(0);
      ph.push_back(1);
      if (v.kind >= 1 && v.kind <= 4) ph.push_back(2);
      if (v.kind == 2 || v.kind == 3) ph.push_back(3);
      if (v.kind == 1 || v.kind == 2) ph.push_back(4);
      pi = 0; cyc = 0; stalls = 0; fd = -1; ended = 0;
      n_wb = 0; n_memw = 0; n_memr = 0; n_pc = 0; n_pcsrc = 0; n_ir = 0;
      e_memw = 0; e_memr = 0; e_pc = 1;
      opcode = v.op;
      while (!ended && cyc < 100) begin
         freeze       = (p_frz != 0) && ($urandom_range(99) < p_frz);
         mem_ready    = !((p_wait != 0) && ($urandom_range(99) < p_wait));
         branch_taken = 1'($urandom_range(1));
         @(negedge clk);
         cur  = ph[pi];
         adv  = !freeze && !((cur == 0 || cur == 3) && !mem_ready);
         last = adv && (pi == ph.size() - 1);
         check("state", state_o, cur);
         check("instr_done", instr_done, last && v.kind != 5);
         check("illegal_op", illegal_op, last && v.kind == 5);
         check("iord", iord, cur == 3);
         if (cur < 2)
            check("dec_idle", {exec_cmd, is_imm, single_src, if_store_bne, branch_type}, 0);
         else
            check("dec_fields", {exec_cmd, is_imm, single_src, if_store_bne, branch_type},
                  {v.cmd, v.imm, v.ss, v.sb, v.bt});
         if (freeze)
            check("frz_strobes", {ir_en, pc_en, mem_r_en, mem_w_en, wb_en, instr_done, illegal_op, mem_err}, 0);
         if ((instr_done || illegal_op) && fd < 0) fd = cyc;
         n_wb    += int'(wb_en);
         n_memw  += int'(mem_w_en);
         n_memr  += int'(mem_r_en);
         n_pc    += int'(pc_en);
         n_pcsrc += int'(pc_en && pc_src);
         n_ir    += int'(ir_en);
         if (!freeze && cur == 0) e_memr++;
         if (!freeze && cur == 3) begin
            if (v.kind == 2) e_memr++;
            else             e_memw++;
         end
         if (adv && cur == 2 && v.kind == 4 && (v.bt == 2'b11 || branch_taken)) e_pc++;
         if (adv) pi++;
         else     stalls++;
         cyc++;
         if (pi == ph.size()) ended = 1;
         @(posedge clk); #1;
      end
      check("ended", ended, 1);
      check("latency", fd + 1, v.lat + stalls);
      check("wb_count", n_wb, (v.kind == 1 || v.kind == 2) ? 1 : 0);
      check("memw_count", n_memw, e_memw);
      check("memr_count", n_memr, e_memr);
      check("pc_en_count", n_pc, e_pc);
      check("pc_src_count", n_pcsrc, e_pc - 1);
      check("ir_en_count", n_ir, 1);
   endtask

   initial begin
      tbl[0]  = mk(6'h00, 0, 2, 4'h0, 0, 0, 0, 2'b00);
      tbl[1]  = mk(6'h01, 1, 4, 4'h0, 0, 0, 0, 2'b00);
      tbl[2]  = mk(6'h03, 1, 4, 4'h2, 0, 0, 0, 2'b00);
      tbl[3]  = mk(6'h05, 1, 4, 4'h4, 0, 0, 0, 2'b00);
      tbl[4]  = mk(6'h06, 1, 4, 4'h5, 0, 0, 0, 2'b00);
      tbl[5]  = mk(6'h07, 1, 4, 4'h6, 0, 0, 0, 2'b00);
      tbl[6]  = mk(6'h08, 1, 4, 4'h7, 0, 0, 0, 2'b00);
      tbl[7]  = mk(6'h09, 1, 4, 4'h8, 0, 0, 0, 2'b00);
      tbl[8]  = mk(6'h0A, 1, 4, 4'h8, 0, 0, 0, 2'b00);
      tbl[9]  = mk(6'h0B, 1, 4, 4'h9, 0, 0, 0, 2'b00);
      tbl[10] = mk(6'h0C, 1, 4, 4'hA, 0, 0, 0, 2'b00);
      tbl[11] = mk(6'h20, 1, 4, 4'h0, 1, 1, 0, 2'b00);
      tbl[12] = mk(6'h21, 1, 4, 4'h2, 1, 1, 0, 2'b00);
      tbl[13] = mk(6'h24, 2, 5, 4'h0, 1, 1, 0, 2'b00);
      tbl[14] = mk(6'h25, 3, 4, 4'h0, 1, 0, 1, 2'b00);
      tbl[15] = mk(6'h28, 4, 3, 4'h0, 1, 1, 0, 2'b01);
      tbl[16] = mk(6'h29, 4, 3, 4'h0, 1, 0, 1, 2'b10);
      tbl[17] = mk(6'h2A, 4, 3, 4'h0, 1, 1, 0, 2'b11);
      tbl[18] = mk(6'h3F, 5, 2, 4'h0, 0, 0, 0, 2'b00);
      tbl[19] = mk(6'h02, 5, 2, 4'h0, 0, 0, 0, 2'b00);
      tbl[20] = mk(6'h04, 5, 2, 4'h0, 0, 0, 0, 2'b00);
      tbl[21] = mk(6'h30, 5, 2, 4'h0, 0, 0, 0, 2'b00);

      rst = 1'b1; freeze = 1'b0; mem_ready = 1'b1; branch_taken = 1'b0; opcode = 6'h00;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      check("reset_outputs", {state_o, ir_en, pc_en, pc_src, iord, mem_r_en, mem_w_en, wb_en,
                              exec_cmd, is_imm, single_src, if_store_bne, branch_type,
                              instr_done, illegal_op, mem_err}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // zero-wait pass over the whole opcode table
      for (int i = 0; i < NV; i++) run_instr(i, 0, 0);

      // LD: freeze two cycles in EXEC, mem_ready low three cycles in MEM -> done on cycle 10
      opcode = 6'h24;
      for (int c = 1; c <= 10; c++) begin
         freeze    = (c == 3 || c == 4);
         mem_ready = !(c >= 6 && c <= 8);
         @(negedge clk);
         check("ld_stall_done", instr_done, c == 10);
         if (freeze) begin
            check("ld_frz_state", state_o, 2);
            check("ld_frz_strobes", {ir_en, pc_en, mem_r_en, mem_w_en, wb_en, instr_done}, 0);
         end
         if (c >= 6 && c <= 9) check("ld_mem_rd", {state_o, mem_r_en, iord}, {3'd3, 1'b1, 1'b1});
         if (c == 10) check("ld_wb", wb_en, 1);
         @(posedge clk); #1;
      end
      freeze = 1'b0;

      // reset (with freeze) while an ST waits in MEM
      opcode = 6'h25; mem_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      mem_ready = 1'b0;
      @(negedge clk);
      check("st_mem_state", state_o, 3);
      check("st_mem_write", mem_w_en & iord, 1);
      rst = 1'b1; freeze = 1'b1;
      #1;
      check("rst_outputs", {state_o, ir_en, pc_en, mem_r_en, mem_w_en, wb_en, instr_done, iord}, 0);
      @(posedge clk); #1;
      rst = 1'b0; freeze = 1'b0;
      @(negedge clk);
      check("rst_restart_state", state_o, 0);
      check("rst_no_memw", mem_w_en, 0);
      check("rst_no_done", instr_done, 0);
      check("rst_fetch_rd", mem_r_en, 1);
      @(posedge clk); #1;

      // randomized instruction stream with memory waits and freezes
      for (int n = 0; n < 300; n++) run_instr($urandom_range(NV - 1), 30, 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
